// File: rtl/data_memory_controller_if.sv
// Pipeline-side and bus-side signals of the data memory controller.
// slave = the controller; master = the pipeline/memory environment driving it.
interface data_memory_controller_if;
  logic        i_memory_read;
  logic        i_memory_write;
  logic [31:0] i_address;
  logic [31:0] i_write_data;
  logic [3:0]  i_write_mask;
  logic        i_misaligned;
  logic [31:0] o_data_memory_read_data;
  logic        o_stall;
  logic        o_access_fault;
  logic        o_misaligned_fault;
  logic        o_bus_request;
  logic        o_bus_write;
  logic [31:0] o_bus_address;
  logic [31:0] o_bus_write_data;
  logic [3:0]  o_bus_write_mask;
  logic        i_bus_ack;
  logic [31:0] i_bus_read_data;
  logic        i_bus_error;

  modport slave (
    input  i_memory_read, i_memory_write, i_address, i_write_data, i_write_mask,
           i_misaligned, i_bus_ack, i_bus_read_data, i_bus_error,
    output o_data_memory_read_data, o_stall, o_access_fault, o_misaligned_fault,
           o_bus_request, o_bus_write, o_bus_address, o_bus_write_data, o_bus_write_mask
  );

  modport master (
    output i_memory_read, i_memory_write, i_address, i_write_data, i_write_mask,
           i_misaligned, i_bus_ack, i_bus_read_data, i_bus_error,
    input  o_data_memory_read_data, o_stall, o_access_fault, o_misaligned_fault,
           o_bus_request, o_bus_write, o_bus_address, o_bus_write_data, o_bus_write_mask
  );
endinterface

// File: rtl/data_memory_controller.sv
// Turns pipeline load/store requests into single word-aligned bus transactions,
// holding the pipeline until ack, bus error or timeout.
module data_memory_controller #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  data_memory_controller_if.slave mif
);
  typedef enum logic [1:0] {S_IDLE, S_REQUEST, S_DONE, S_FAULT} state_t;
  localparam logic [7:0] TC_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [3:0]  r_mask;

  logic w_active;
  logic w_valid;
  logic w_resp;
  logic w_timeout;
  logic w_stall;
  logic w_mis_fault;
  logic w_bus_req;
  logic w_acc_fault;
  logic w_latch;
  logic w_capture;

  assign w_active  = mif.i_memory_read | mif.i_memory_write;
  // A store with no enabled lanes has nothing to do on the bus
  assign w_valid   = w_active & ~mif.i_misaligned &
                     ~(mif.i_memory_write & (mif.i_write_mask == 4'b0000));
  assign w_resp    = mif.i_bus_ack | mif.i_bus_error;
  assign w_timeout = (r_cnt == TC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_valid) w_state_nxt = S_REQUEST;
      S_REQUEST: begin
        if (mif.i_bus_error)    w_state_nxt = S_FAULT;
        else if (mif.i_bus_ack) w_state_nxt = S_DONE;
        else if (w_timeout)     w_state_nxt = S_FAULT;
      end
      S_DONE:    w_state_nxt = S_IDLE;
      S_FAULT:   w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_stall     = 1'b0;
    w_mis_fault = 1'b0;
    w_bus_req   = 1'b0;
    w_acc_fault = 1'b0;
    w_latch     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall     = w_valid;
        w_latch     = w_valid;
        w_mis_fault = w_active & mif.i_misaligned;
      end
      S_REQUEST: begin
        w_stall   = 1'b1;
        w_bus_req = 1'b1;
        w_capture = mif.i_bus_ack & ~mif.i_bus_error & ~r_write;
      end
      S_FAULT:  w_acc_fault = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_mask  <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_latch) begin
        r_write <= mif.i_memory_write;
        r_addr  <= mif.i_address & 32'hFFFF_FFFC;
        r_wdata <= mif.i_write_data;
        r_mask  <= mif.i_write_mask;
        r_cnt   <= 8'd0;
      end else if (r_state == S_REQUEST && !w_resp) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_capture) r_rdata <= mif.i_bus_read_data;
    end
  end

  // Comb outputs fed by pipeline inputs are forced low while reset is held
  assign mif.o_stall                 = w_stall & ~rst;
  assign mif.o_misaligned_fault      = w_mis_fault & ~rst;
  assign mif.o_bus_request           = w_bus_req;
  assign mif.o_access_fault          = w_acc_fault;
  assign mif.o_bus_write             = r_write;
  assign mif.o_bus_address           = r_addr;
  assign mif.o_bus_write_data        = r_wdata;
  assign mif.o_bus_write_mask        = r_write ? r_mask : 4'b0000;
  assign mif.o_data_memory_read_data = r_rdata;
endmodule

// File: tb/tb_data_memory_controller.sv
// Bench for data_memory_controller: directed vector table, reset-abandon sequence,
// and randomized transactions checked against a transaction-level model.
module tb_data_memory_controller;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_memory_controller_if mif();
  data_memory_controller #(.TIMEOUT_CYCLES(T)) dut (.clk(clk), .rst(rst), .mif(mif));

  int total = 0;
  int bad = 0;
  logic [31:0] model_rd = 32'h0;

  typedef struct {
    logic rd; logic wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] mask; logic mis;
    int idx; logic ack; logic err; logic [31:0] rdata;
    int e_stall; int e_breq; logic e_fault; logic e_mis;
    logic [31:0] e_baddr; logic e_bwrite; logic [3:0] e_bmask; logic [31:0] e_rdreg;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mif.i_memory_read  = 1'b0;
    mif.i_memory_write = 1'b0;
    mif.i_address      = '0;
    mif.i_write_data   = '0;
    mif.i_write_mask   = '0;
    mif.i_misaligned   = 1'b0;
    mif.i_bus_ack      = 1'b0;
    mif.i_bus_error    = 1'b0;
    mif.i_bus_read_data = '0;
  endtask

  // Transaction-level expectation: outcome decided by which response arrives first
  task automatic model(inout vec_t v);
    logic valid;
    valid = (v.rd | v.wr) & ~v.mis & ~(v.wr & (v.mask == 4'b0000));
    v.e_mis    = (v.rd | v.wr) & v.mis;
    v.e_bwrite = v.wr;
    v.e_baddr  = {v.addr[31:2], 2'b00};
    v.e_bmask  = v.wr ? v.mask : 4'b0000;
    if (!valid) begin
      v.e_stall = 0; v.e_breq = 0; v.e_fault = 1'b0;
    end else if ((v.ack || v.err) && v.idx <= T) begin
      v.e_breq  = v.idx;
      v.e_stall = v.idx + 1;
      v.e_fault = v.err;
      if (!v.err && !v.wr) model_rd = v.rdata;
    end else begin
      v.e_breq = T; v.e_stall = T + 1; v.e_fault = 1'b1;
    end
    v.e_rdreg = model_rd;
  endtask

  task automatic apply(input string tag, input vec_t v);
    int stall_n, breq_n, fault_n, unstable, cyc;
    logic mis_seen, bwrite, done;
    logic [31:0] baddr, bwdata;
    logic [3:0] bmask;
    @(negedge clk);
    mif.i_memory_read  = v.rd;
    mif.i_memory_write = v.wr;
    mif.i_address      = v.addr;
    mif.i_write_data   = v.wdata;
    mif.i_write_mask   = v.mask;
    mif.i_misaligned   = v.mis;
    mif.i_bus_ack      = 1'b0;
    mif.i_bus_error    = 1'b0;
    #1;
    stall_n  = mif.o_stall ? 1 : 0;
    fault_n  = mif.o_access_fault ? 1 : 0;
    mis_seen = mif.o_misaligned_fault;
    breq_n = 0; unstable = 0; cyc = 0;
    baddr = '0; bwdata = '0; bmask = '0; bwrite = 1'b0;
    done = !mif.o_stall;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      mif.i_bus_ack   = 1'b0;
      mif.i_bus_error = 1'b0;
      if (mif.o_bus_request) begin
        breq_n++;
        if (breq_n == 1) begin
          baddr = mif.o_bus_address; bwdata = mif.o_bus_write_data;
          bmask = mif.o_bus_write_mask; bwrite = mif.o_bus_write;
        end else if (baddr !== mif.o_bus_address || bwdata !== mif.o_bus_write_data ||
                     bmask !== mif.o_bus_write_mask || bwrite !== mif.o_bus_write) begin
          unstable++;
        end
        if (breq_n == v.idx) begin
          mif.i_bus_ack       = v.ack;
          mif.i_bus_error     = v.err;
          mif.i_bus_read_data = v.rdata;
        end
      end
      #1;
      if (mif.o_stall) stall_n++;
      if (mif.o_access_fault) fault_n++;
      if (!mif.o_stall) done = 1'b1;
    end
    chk({tag, " hang"}, 32'(!done), 32'h0);
    @(negedge clk);
    idle_inputs();
    #1;
    if (mif.o_bus_request) breq_n++;
    if (mif.o_stall) stall_n++;
    if (mif.o_access_fault) fault_n++;
    chk({tag, " stall_cycles"}, 32'(stall_n), 32'(v.e_stall));
    chk({tag, " bus_req_cycles"}, 32'(breq_n), 32'(v.e_breq));
    chk({tag, " access_fault_cycles"}, 32'(fault_n), 32'(v.e_fault));
    chk({tag, " misaligned_fault"}, 32'(mis_seen), 32'(v.e_mis));
    if (v.e_breq > 0) begin
      chk({tag, " bus_address"}, baddr, v.e_baddr);
      chk({tag, " bus_write"}, 32'(bwrite), 32'(v.e_bwrite));
      chk({tag, " bus_write_mask"}, 32'(bmask), 32'(v.e_bmask));
      if (v.e_bwrite) chk({tag, " bus_write_data"}, bwdata, v.wdata);
      chk({tag, " bus_stable"}, 32'(unstable), 32'h0);
    end
    chk({tag, " read_data_reg"}, mif.o_data_memory_read_data, v.e_rdreg);
  endtask

  initial begin
    idle_inputs();
    //            rd wr addr            wdata         mask    mis idx ack err rdata          stl breq flt mis baddr          bw bmask   rdreg
    vecs[0] = '{1, 0, 32'h000000F2, 32'h00000000, 4'b0000, 0, 3, 1, 0, 32'hCAFEBEBE, 4, 3, 0, 0, 32'h000000F0, 0, 4'b0000, 32'hCAFEBEBE};
    vecs[1] = '{0, 1, 32'h000000F1, 32'hEFEFEFEF, 4'b0010, 0, 1, 1, 0, 32'h00000000, 2, 1, 0, 0, 32'h000000F0, 1, 4'b0010, 32'hCAFEBEBE};
    vecs[2] = '{1, 0, 32'h00000101, 32'h00000000, 4'b0000, 1, 1, 1, 0, 32'h11111111, 0, 0, 0, 1, 32'h00000000, 0, 4'b0000, 32'hCAFEBEBE};
    vecs[3] = '{1, 0, 32'h00000080, 32'h00000000, 4'b0000, 0, 1, 1, 1, 32'h12345678, 2, 1, 1, 0, 32'h00000080, 0, 4'b0000, 32'hCAFEBEBE};
    vecs[4] = '{1, 0, 32'h00000200, 32'h00000000, 4'b0000, 0, 1, 0, 0, 32'h00000000, 5, 4, 1, 0, 32'h00000200, 0, 4'b0000, 32'hCAFEBEBE};
    vecs[5] = '{0, 1, 32'h00000300, 32'hA5A5A5A5, 4'b0000, 0, 1, 1, 0, 32'h00000000, 0, 0, 0, 0, 32'h00000000, 0, 4'b0000, 32'hCAFEBEBE};
    vecs[6] = '{1, 1, 32'h00001003, 32'h11223344, 4'b1111, 0, 2, 1, 0, 32'hDEADDEAD, 3, 2, 0, 0, 32'h00001000, 1, 4'b1111, 32'hCAFEBEBE};
    vecs[7] = '{1, 0, 32'hABCD0004, 32'h00000000, 4'b0000, 0, 4, 1, 0, 32'h0BADF00D, 5, 4, 0, 0, 32'hABCD0004, 0, 4'b0000, 32'h0BADF00D};
    vecs[8] = '{0, 1, 32'h7777777A, 32'h01020304, 4'b0100, 0, 2, 0, 1, 32'h00000000, 3, 2, 1, 0, 32'h77777778, 1, 4'b0100, 32'h0BADF00D};
    vecs[9] = '{0, 1, 32'h00000055, 32'hFFFF0000, 4'b0011, 1, 1, 1, 0, 32'h00000000, 0, 0, 0, 1, 32'h00000000, 0, 4'b0000, 32'h0BADF00D};

    #2;
    chk("reset stall", 32'(mif.o_stall), 32'h0);
    chk("reset bus_request", 32'(mif.o_bus_request), 32'h0);
    chk("reset access_fault", 32'(mif.o_access_fault), 32'h0);
    chk("reset bus_write", 32'(mif.o_bus_write), 32'h0);
    chk("reset bus_address", mif.o_bus_address, 32'h0);
    chk("reset bus_write_data", mif.o_bus_write_data, 32'h0);
    chk("reset bus_write_mask", 32'(mif.o_bus_write_mask), 32'h0);
    chk("reset read_data_reg", mif.o_data_memory_read_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) apply($sformatf("vec%0d", i), vecs[i]);

    // Reset in the second REQUEST cycle abandons the read; a late ack is ignored
    @(negedge clk);
    mif.i_memory_read = 1'b1;
    mif.i_address     = 32'h00000040;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_mid bus_request_before", 32'(mif.o_bus_request), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_mid bus_request", 32'(mif.o_bus_request), 32'h0);
    chk("rst_mid stall", 32'(mif.o_stall), 32'h0);
    chk("rst_mid access_fault", 32'(mif.o_access_fault), 32'h0);
    chk("rst_mid read_data_reg", mif.o_data_memory_read_data, 32'h0);
    chk("rst_mid bus_address", mif.o_bus_address, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    mif.i_bus_ack       = 1'b1;
    mif.i_bus_read_data = 32'h55AA55AA;
    #1;
    chk("late_ack bus_request", 32'(mif.o_bus_request), 32'h0);
    chk("late_ack stall", 32'(mif.o_stall), 32'h0);
    @(negedge clk);
    mif.i_bus_ack = 1'b0;
    #1;
    chk("late_ack read_data_reg", mif.o_data_memory_read_data, 32'h0);
    chk("late_ack access_fault", 32'(mif.o_access_fault), 32'h0);
    chk("late_ack bus_request_after", 32'(mif.o_bus_request), 32'h0);
    model_rd = 32'h0;

    for (int n = 0; n < 60; n++) begin
      vec_t v;
      v.rd    = 1'($urandom_range(0, 1));
      v.wr    = 1'($urandom_range(0, 1));
      v.addr  = $urandom;
      v.wdata = $urandom;
      v.mask  = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom);
      v.mis   = ($urandom_range(0, 7) == 0);
      v.idx   = int'($urandom_range(1, T + 2));
      v.rdata = $urandom;
      case ($urandom_range(0, 3))
        0:       begin v.ack = 1'b1; v.err = 1'b0; end
        1:       begin v.ack = 1'b0; v.err = 1'b1; end
        2:       begin v.ack = 1'b1; v.err = 1'b1; end
        default: begin v.ack = 1'b0; v.err = 1'b0; end
      endcase
      model(v);
      apply($sformatf("rnd%0d", n), v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_memory_controller.md
DATA_MEMORY_CONTROLLER -- requirements
Module: data_memory_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, maximum cycles REQUEST waits for bus_ack/bus_error before faulting (legal range 2..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 memory_read  input  1  load request from pipeline.
REQ-005 memory_write  input  1  store request from pipeline.
REQ-006 address  input  32  byte address of access.
REQ-007 write_data  input  32  lane-duplicated store data from byte enable logic.
REQ-008 write_mask  input  4  byte lanes to write.
REQ-009 misaligned  input  1  access misaligned for its funct3.
REQ-010 data_memory_read_data  output  32  registered word returned to byte enable logic.
REQ-011 stall  output  1  pipeline must hold while high.
REQ-012 access_fault  output  1  one-cycle pulse: bus error or timeout.
REQ-013 misaligned_fault  output  1  request rejected as misaligned.
REQ-014 bus_request  output  1  external bus request.
REQ-015 bus_write  output  1  1 = write, 0 = read.
REQ-016 bus_address  output  32  word-aligned address, bits [1:0] = 00.
REQ-017 bus_write_data  output  32  latched store data.
REQ-018 bus_write_mask  output  4  latched mask; 4'b0000 on reads.
REQ-019 bus_ack  input  1  transaction complete; bus_read_data valid this cycle.
REQ-020 bus_read_data  input  32  read word from memory.
REQ-021 bus_error  input  1  transaction failed.

Function
REQ-022 States SHALL be IDLE, REQUEST, DONE, FAULT.
REQ-023 Valid request in IDLE = (memory_read|memory_write) & ~misaligned & ~(memory_write & write_mask==0).
- Valid request in IDLE: stall=1 combinationally the same cycle; latch address[31:2], write_data, write_mask, direction; next state REQUEST.
REQ-024 memory_read & memory_write together SHALL be treated as a write.
REQ-025 Misaligned request in IDLE: misaligned_fault=1 combinationally, stall=0, no bus transaction, state stays IDLE.
REQ-026 Write with write_mask 4'b0000: no bus transaction, stall=0, no fault.
REQ-027 REQUEST: bus_request=1, stall=1; bus_* outputs driven from latches and stable until exit; pipeline inputs ignored.
REQ-028 REQUEST, bus_ack=1, bus_error=0: on a read, capture bus_read_data into data_memory_read_data; next state DONE.
REQ-029 REQUEST, bus_error=1: next state FAULT; bus_error takes priority over a simultaneous bus_ack, and data register is not updated.
REQ-030 Timeout counter: 8 bits, cleared on entry to REQUEST, incremented each REQUEST cycle without ack/error; at TIMEOUT_CYCLES-1 with no ack/error, next state FAULT.
REQ-031 DONE: stall=0, bus_request=0 for exactly one cycle; inputs ignored; next state IDLE.
REQ-032 FAULT: access_fault=1, stall=0, bus_request=0 for exactly one cycle; next state IDLE.
REQ-033 Bus latency SHALL be load/store issue to pipeline release = (ack cycle index + 2) cycles; zero-wait ack gives stall high for 2 cycles.
REQ-034 data_memory_read_data holds its value except on REQ-028 capture; writes never alter it.
REQ-035 bus_write_mask = latched write_mask on writes, 4'b0000 on reads.

Reset
REQ-036 reset high SHALL immediately force state IDLE, stall=0, bus_request=0, bus_write=0, bus_address=0, bus_write_data=0, bus_write_mask=0, access_fault=0, data_memory_read_data=0, timeout counter=0.
REQ-037 Reset asserted mid-REQUEST SHALL abandon the transaction with no fault pulse; a bus_ack arriving after reset deasserts SHALL be ignored in IDLE.

Verification
REQ-038 Read, address 0x000000F2, bus_ack on 3rd REQUEST cycle with bus_read_data 0xCAFEBEBE -> bus_address 0x000000F0, bus_write 0, stall high 4 cycles, data_memory_read_data 0xCAFEBEBE from DONE onward.
REQ-039 Write, address 0x000000F1, write_data 0xEFEFEFEF, mask 4'b0010, zero-wait ack -> bus_write_mask 0010, bus_write_data 0xEFEFEFEF, stall high 2 cycles, read data register unchanged.
REQ-040 Read with misaligned=1 -> misaligned_fault=1 same cycle, stall=0, bus_request never asserted.
REQ-041 Read, bus_ack and bus_error together on 1st REQUEST cycle -> FAULT, access_fault one-cycle pulse, data register unchanged.
REQ-042 Read, no ack, TIMEOUT_CYCLES=4 -> bus_request high exactly 4 cycles, then access_fault pulse, IDLE.
REQ-043 Reset asserted in 2nd REQUEST cycle -> bus_request and stall low immediately, data register 0, late bus_ack ignored.
